// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's data load/store port. It holds one
// transaction at a time. A request is accepted on a valid/ready handshake,
// and the response is returned LATENCY clock edges later on a second
// valid/ready channel. Storage is 2^MEM_WIDTH bytes, little-endian, and
// supports byte, halfword and word accesses. Loads sign- or zero-extend.
//
// Stores are written and load data is read and extended on the acceptance
// edge. After that edge the request inputs are never looked at again, so the
// initiator may change them while the response is pending.
//
// Ports
//   clk            in   1          clock, rising edge
//   rst            in   1          asynchronous reset, active high
//   req_valid_i    in   1          request present
//   req_ready_o    out  1          responder idle, can accept a request
//   req_write_i    in   1          1 = store, 0 = load
//   req_addr_i     in   MEM_WIDTH  byte address
//   req_wdata_i    in   32         store data, low bytes used per size
//   req_size_i     in   2          00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned_i in   1          zero-extend (1) / sign-extend (0) loads
//   rsp_valid_o    out  1          response present
//   rsp_ready_i    in   1          initiator takes the response
//   rsp_rdata_o    out  32         load data, 0 for stores and errors
//   rsp_error_o    out  1          misaligned address or reserved size
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int MEM_WIDTH = 8,
    parameter int LATENCY   = 2     // 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [MEM_WIDTH-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // WAIT always lasts LATENCY cycles. This includes LATENCY = 1. As a result
    // rsp_valid_o rises exactly LATENCY edges after the acceptance edge.
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;
    logic                 w_accept;
    logic                 w_error;
    logic                 w_store;
    logic [MEM_WIDTH-1:0] w_a1;
    logic [MEM_WIDTH-1:0] w_a2;
    logic [MEM_WIDTH-1:0] w_a3;
    logic [7:0]           w_b0;
    logic [7:0]           w_b1;
    logic [7:0]           w_b2;
    logic [7:0]           w_b3;
    logic [31:0]          w_load;
    logic [31:0]          w_rdata_next;
    logic [31:0]          r_rdata;
    logic                 r_error;

    logic [7:0] r_mem [0:(2**MEM_WIDTH)-1];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // Aligned accesses never cross the top of storage. Wrapping MEM_WIDTH-bit
    // sums are therefore safe, and they keep every index in range.
    assign w_a1 = req_addr_i + MEM_WIDTH'(1);
    assign w_a2 = req_addr_i + MEM_WIDTH'(2);
    assign w_a3 = req_addr_i + MEM_WIDTH'(3);

    assign w_b0 = r_mem[req_addr_i];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        // NOTE: every variable written here gets a default first. A path
        // that skips an assignment would otherwise infer a latch.
        w_error = 1'b0;
        w_load  = 32'h0;
        case (req_size_i)
            SZ_BYTE: begin
                w_load = {{24{~req_unsigned_i & w_b0[7]}}, w_b0};
            end
            SZ_HALF: begin
                w_error = req_addr_i[0];
                w_load  = {{16{~req_unsigned_i & w_b1[7]}}, w_b1, w_b0};
            end
            SZ_WORD: begin
                w_error = |req_addr_i[1:0];
                w_load  = {w_b3, w_b2, w_b1, w_b0};
            end
            default: begin
                w_error = 1'b1;
            end
        endcase
    end

    assign w_rdata_next = (req_write_i || w_error) ? 32'h0 : w_load;

    // While rst is high the FSM sits in IDLE. A request seen then must not
    // reach storage.
    assign w_store = w_accept && req_write_i && !w_error && !rst;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                    w_cnt_next   = 4'd0;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_RESP;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks evaluate in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The response register is loaded once per transaction. It then holds
    // its value through WAIT and any amount of RESP backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_rdata_next;
            r_error <= w_error;
        end
    end

    assign rsp_rdata_o = r_rdata;
    assign rsp_error_o = r_error;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the byte array has no reset. Its contents survive rst, and a
    // reset branch here would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[req_addr_i] <= req_wdata_i[7:0];
            if (req_size_i != SZ_BYTE) begin
                r_mem[w_a1] <= req_wdata_i[15:8];
            end
            if (req_size_i == SZ_WORD) begin
                r_mem[w_a2] <= req_wdata_i[23:16];
                r_mem[w_a3] <= req_wdata_i[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// u0 uses LATENCY = 2 and runs directed and random single transactions.
// u1 uses LATENCY = 1 and is fed a continuous request stream.
// Expected values come from a byte-array model that applies the access rules
// directly.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    logic        u1_req_valid, u1_req_ready, u1_req_write, u1_req_unsigned;
    logic [7:0]  u1_req_addr;
    logic [31:0] u1_req_wdata;
    logic [1:0]  u1_req_size;
    logic        u1_rsp_valid, u1_rsp_ready, u1_rsp_error;
    logic [31:0] u1_rsp_rdata;

    data_mem_responder #(.MEM_WIDTH(8), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error)
    );

    data_mem_responder #(.MEM_WIDTH(8), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid_i(u1_req_valid), .req_ready_o(u1_req_ready),
        .req_write_i(u1_req_write), .req_addr_i(u1_req_addr),
        .req_wdata_i(u1_req_wdata), .req_size_i(u1_req_size),
        .req_unsigned_i(u1_req_unsigned),
        .rsp_valid_o(u1_rsp_valid), .rsp_ready_i(u1_rsp_ready),
        .rsp_rdata_o(u1_rsp_rdata), .rsp_error_o(u1_rsp_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one byte array per instance.
    // Returns {error, rdata}.
    // ------------------------------------------------------------------
    logic [7:0] model_mem [2][256];

    function automatic logic [32:0] model_access(input int m, input logic w, input logic [7:0] a,
                                                 input logic [31:0] wd, input logic [1:0] sz,
                                                 input logic uns);
        int          nb;
        logic [31:0] v;
        if (sz == 2'd3) return {1'b1, 32'h0};
        nb = 1 << sz;
        if ((int'(a) % nb) != 0) return {1'b1, 32'h0};
        if (w) begin
            for (int i = 0; i < nb; i++) model_mem[m][int'(a) + i] = wd[8*i +: 8];
            return 33'h0;
        end
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(model_mem[m][int'(a) + i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        return {1'b0, v};
    endfunction

    logic [31:0] exp_rdata;
    logic        exp_err;

    // Each task starts and ends just after a falling edge.
    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns);
        req_write    = w;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
        req_valid    = 1'b1;
        check("req_ready_idle", req_ready, 1);
        {exp_err, exp_rdata} = model_access(0, w, a, wd, sz, uns);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request inputs. The DUT must ignore them from here on.
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = 8'($urandom);
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
    endtask

    task automatic await_rsp(input int hold);
        int cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            check("req_ready_busy", req_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 2);
        check("req_ready_resp", req_ready, 0);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_error", rsp_error, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_error", rsp_error, exp_err);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_ready", req_ready, 1);
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input int hold);
        send(w, a, wd, sz, uns);
        await_rsp(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] q[$];
        logic [32:0] e;
        int          n_acc, n_rsp, last;
        logic        w;
        logic [7:0]  a;
        logic [1:0]  sz;

        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_unsigned = 0; rsp_ready = 0;
        u1_req_valid = 0; u1_req_write = 0; u1_req_addr = 0; u1_req_wdata = 0;
        u1_req_size = 0; u1_req_unsigned = 0; u1_rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_u1_ready", u1_req_ready, 1);
        check("rst_u1_valid", u1_rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed sequence
        xfer(1, 8'h10, 32'hDEADBEEF, 2'b10, 0, 0);
        for (int i = 0; i < 4; i++) xfer(0, 8'(8'h10 + i), 0, 2'b00, 1, 0);
        xfer(0, 8'h13, 0, 2'b00, 0, 0);
        xfer(0, 8'h12, 0, 2'b01, 0, 0);
        xfer(0, 8'h12, 0, 2'b01, 1, 0);
        xfer(1, 8'h11, 32'h1234, 2'b01, 0, 0);
        xfer(0, 8'h10, 0, 2'b10, 0, 0);
        xfer(1, 8'h20, 32'h5555AAAA, 2'b11, 0, 0);
        xfer(0, 8'h10, 0, 2'b10, 0, 5);

        // Reset while a store sits in WAIT
        req_write = 1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D;
        req_size = 2'b10; req_unsigned = 0; req_valid = 1;
        check("req_ready_idle", req_ready, 1);
        void'(model_access(0, 1, 8'h40, 32'hCAFEF00D, 2'b10, 0));
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("wait_valid", rsp_valid, 0);
        check("wait_ready", req_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_wait_ready", req_ready, 1);
        check("rst_wait_valid", rsp_valid, 0);
        check("rst_wait_rdata", rsp_rdata, 0);
        check("rst_wait_error", rsp_error, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 0);
        end

        // Reset while a load response is waiting in RESP
        send(0, 8'h10, 0, 2'b10, 0);
        @(negedge clk);
        @(negedge clk);
        check("resp_before_rst", rsp_rdata, exp_rdata);
        #1 rst = 1'b1;
        #1;
        check("rst_resp_rdata", rsp_rdata, 0);
        check("rst_resp_valid", rsp_valid, 0);
        check("rst_resp_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xfer(0, 8'h40, 0, 2'b10, 0, 0);

        // Random phase on u0. Fill all storage first so every load is defined.
        for (int i = 0; i < 256; i += 4) xfer(1, 8'(i), $urandom, 2'b10, 0, 0);
        for (int i = 0; i < 60; i++) begin
            w  = ($urandom_range(0, 3) == 0);
            a  = 8'($urandom);
            sz = 2'($urandom_range(0, 3));
            xfer(w, a, $urandom, sz, 1'($urandom), $urandom_range(0, 2));
        end

        // u1: LATENCY 1, req_valid held high, rsp_ready held high
        n_acc = 0; n_rsp = 0; last = -1;
        u1_rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (u1_rsp_valid) begin
                n_rsp++;
                if (q.size() == 0) begin
                    check("s1_extra_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("s1_rdata", u1_rsp_rdata, e[31:0]);
                    check("s1_error", u1_rsp_error, e[32]);
                end
            end
            if (u1_req_ready) begin
                if (n_acc < 24) begin
                    if (last >= 0) check("s1_spacing", cyc - last, 3);
                    last = cyc;
                    if (n_acc < 8) begin
                        w = 1; a = 8'(n_acc * 4); sz = 2'b10;
                    end else begin
                        w = ($urandom_range(0, 3) == 0);
                        a = 8'($urandom_range(0, 31));
                        sz = 2'($urandom_range(0, 3));
                    end
                    u1_req_write    = w;
                    u1_req_addr     = a;
                    u1_req_wdata    = $urandom;
                    u1_req_size     = sz;
                    u1_req_unsigned = 1'($urandom);
                    u1_req_valid    = 1'b1;
                    q.push_back(model_access(1, w, a, u1_req_wdata, sz, u1_req_unsigned));
                    n_acc++;
                end else begin
                    u1_req_valid = 1'b0;
                end
            end else begin
                u1_req_write    = 1'($urandom);
                u1_req_addr     = 8'($urandom);
                u1_req_wdata    = $urandom;
                u1_req_size     = 2'($urandom);
                u1_req_unsigned = 1'($urandom);
            end
            @(negedge clk);
        end
        check("s1_accepts", n_acc, 24);
        check("s1_responses", n_rsp, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
